caf_sweep_ctrl: RTL and testbench

- Parametrised successor to the single-shot CAF top. Captures a block of complex samples into internal memory.
- For every lag, streams the aligned capture window to an external frequency-shift/correlator bank.
- Collects NUM_FREQ correlation magnitudes per lag and tracks the global peak.
- Emits one peak record (freq index, lag, magnitude) per capture. Sits between the sample source and the CAF result consumer.

---
 rtl/caf_pkg.sv | 36 +++
 rtl/caf_cap_mem.sv | 30 +++
 rtl/caf_sweep_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_caf_sweep_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/caf_pkg.sv
// Shared types and helpers for the CAF sweep controller.
package caf_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    CAPTURE  = 4'd1,
    STREAM   = 4'd2,
    WAIT_RES = 4'd3,
    SCAN     = 4'd4,
    REPORT   = 4'd5
  } caf_state_e;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    if (value > 1) begin
      for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
        r++;
      end
    end
    return r;
  endfunction

  // Peak record layout: {mag, lag, freq}, freq in the LSBs.
  localparam int unsigned REC_FREQ_LSB = 0;

  function automatic int unsigned rec_lag_lsb(input int unsigned freq_w);
    return freq_w;
  endfunction

  function automatic int unsigned rec_mag_lsb(input int unsigned freq_w, input int unsigned lag_w);
    return freq_w + lag_w;
  endfunction

endpackage

// File: rtl/caf_cap_mem.sv
// Capture buffer: simple dual-port RAM, one write port, registered read port.
module caf_cap_mem
  import caf_pkg::*;
#(
  parameter  int unsigned DEPTH = 64,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned AW    = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port and registered read port; read data holds while re_i is low.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/caf_sweep_ctrl.sv
// CAF sweep controller: capture a sample block, stream every lag window to the
// correlator bank, scan returned magnitudes and report the global peak.
// Optional build macro CAF_SWEEP_THRESHOLD_EN adds threshold / m_axis_tuser.
module caf_sweep_ctrl
  import caf_pkg::*;
#(
  parameter  int unsigned CAP_LEN     = 64,
  parameter  int unsigned REF_LEN     = 32,
  parameter  int unsigned SAMPLE_BITS = 32,
  parameter  int unsigned NUM_FREQ    = 4,
  parameter  int unsigned MAG_BITS    = 32,
  localparam int unsigned NUM_LAGS    = CAP_LEN - REF_LEN + 1,
  localparam int unsigned CAP_AW      = clog2(CAP_LEN),
  localparam int unsigned REF_AW      = clog2(REF_LEN),
  localparam int unsigned LAG_W       = (clog2(NUM_LAGS) > 0) ? clog2(NUM_LAGS) : 1,
  localparam int unsigned FREQ_W      = (clog2(NUM_FREQ) > 0) ? clog2(NUM_FREQ) : 1,
  localparam int unsigned REC_W       = MAG_BITS + LAG_W + FREQ_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [SAMPLE_BITS-1:0]       s_axis_tdata,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  output logic [SAMPLE_BITS-1:0]       corr_tdata,
  output logic [REF_AW-1:0]            corr_ref_idx,
  output logic [LAG_W-1:0]             corr_lag,
  output logic                         corr_tvalid,
  output logic                         corr_tlast,
  input  logic                         corr_tready,
  input  logic [NUM_FREQ*MAG_BITS-1:0] res_tdata,
  input  logic                         res_tvalid,
  output logic                         res_tready,
  output logic [REC_W-1:0]             m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready
`ifdef CAF_SWEEP_THRESHOLD_EN
  ,
  input  logic [MAG_BITS-1:0]          threshold,
  output logic                         m_axis_tuser
`endif
);

  localparam int unsigned K_W          = REF_AW + 1;
  localparam int unsigned REC_LAG_LSB  = rec_lag_lsb(FREQ_W);
  localparam int unsigned REC_MAG_LSB  = rec_mag_lsb(FREQ_W, LAG_W);

  localparam logic [CAP_AW-1:0] CAP_LAST    = CAP_AW'(CAP_LEN - 1);
  localparam logic [REF_AW-1:0] REF_LAST    = REF_AW'(REF_LEN - 1);
  localparam logic [K_W-1:0]    REF_CNT_END = K_W'(REF_LEN);
  localparam logic [LAG_W-1:0]  LAG_LAST    = LAG_W'(NUM_LAGS - 1);
  localparam logic [FREQ_W-1:0] FREQ_LAST   = FREQ_W'(NUM_FREQ - 1);

  caf_state_e          state_q, state_d;
  logic [CAP_AW-1:0]   wr_addr_q, wr_addr_d;
  logic                s_rdy_q, s_rdy_d;
  logic [LAG_W-1:0]    lag_q, lag_d;
  logic [K_W-1:0]      rd_cnt_q, rd_cnt_d;
  logic                vld_q, vld_d;
  logic [REF_AW-1:0]   out_k_q, out_k_d;
  logic [FREQ_W-1:0]   scan_k_q, scan_k_d;
  logic [MAG_BITS-1:0] res_q [NUM_FREQ];
  logic [MAG_BITS-1:0] peak_mag_q, peak_mag_d;
  logic [LAG_W-1:0]    peak_lag_q, peak_lag_d;
  logic [FREQ_W-1:0]   peak_freq_q, peak_freq_d;

  logic                   mem_we;
  logic [CAP_AW-1:0]      mem_waddr;
  logic                   mem_re;
  logic [CAP_AW-1:0]      mem_raddr;
  logic [SAMPLE_BITS-1:0] mem_rdata;
  logic                   res_we;
  logic [MAG_BITS-1:0]    mag_k;
  logic [REC_W-1:0]       rec;

  caf_cap_mem #(
    .DEPTH (CAP_LEN),
    .WIDTH (SAMPLE_BITS)
  ) u_cap_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (s_axis_tdata),
    .re_i    (mem_re),
    .raddr_i (mem_raddr),
    .rdata_o (mem_rdata)
  );

  // Next-state, memory control and peak update.
  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    lag_d       = lag_q;
    rd_cnt_d    = rd_cnt_q;
    vld_d       = vld_q;
    out_k_d     = out_k_q;
    scan_k_d    = scan_k_q;
    peak_mag_d  = peak_mag_q;
    peak_lag_d  = peak_lag_q;
    peak_freq_d = peak_freq_q;
    mem_we      = 1'b0;
    mem_waddr   = wr_addr_q;
    mem_re      = 1'b0;
    mem_raddr   = CAP_AW'(lag_q) + CAP_AW'(rd_cnt_q);
    res_we      = 1'b0;
    mag_k       = res_q[scan_k_q];

    unique case (state_q)
      IDLE: begin
        if (s_rdy_q && s_axis_tvalid) begin
          mem_we    = 1'b1;
          mem_waddr = '0;
          wr_addr_d = CAP_AW'(1);
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (s_rdy_q && s_axis_tvalid) begin
          mem_we    = 1'b1;
          wr_addr_d = wr_addr_q + 1'b1;
          if (wr_addr_q == CAP_LAST) begin
            wr_addr_d = '0;
            lag_d     = '0;
            rd_cnt_d  = '0;
            state_d   = STREAM;
          end
        end
      end
      STREAM: begin
        if (vld_q && corr_tready) begin
          vld_d = 1'b0;
        end
        // The RAM output register is the output slot: refill it only when empty
        // or being consumed, so a stalled beat holds and handshakes run 1/cycle.
        if ((rd_cnt_q != REF_CNT_END) && (!vld_q || corr_tready)) begin
          mem_re   = 1'b1;
          vld_d    = 1'b1;
          out_k_d  = rd_cnt_q[REF_AW-1:0];
          rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (vld_q && corr_tready && (out_k_q == REF_LAST)) begin
          state_d = WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (res_tvalid) begin
          res_we   = 1'b1;
          scan_k_d = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (mag_k > peak_mag_q) begin
          peak_mag_d  = mag_k;
          peak_lag_d  = lag_q;
          peak_freq_d = scan_k_q;
        end
        if (scan_k_q == FREQ_LAST) begin
          if (lag_q == LAG_LAST) begin
            state_d = REPORT;
          end else begin
            lag_d    = lag_q + 1'b1;
            rd_cnt_d = '0;
            state_d  = STREAM;
          end
        end else begin
          scan_k_d = scan_k_q + 1'b1;
        end
      end
      REPORT: begin
        if (m_axis_tready) begin
          peak_mag_d  = '0;
          peak_lag_d  = '0;
          peak_freq_d = '0;
          lag_d       = '0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_rdy_d = (state_d == IDLE) || (state_d == CAPTURE);
  end

  // State, counters and peak registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_addr_q   <= '0;
      s_rdy_q     <= 1'b0;
      lag_q       <= '0;
      rd_cnt_q    <= '0;
      vld_q       <= 1'b0;
      out_k_q     <= '0;
      scan_k_q    <= '0;
      peak_mag_q  <= '0;
      peak_lag_q  <= '0;
      peak_freq_q <= '0;
      for (int unsigned i = 0; i < NUM_FREQ; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      s_rdy_q     <= s_rdy_d;
      lag_q       <= lag_d;
      rd_cnt_q    <= rd_cnt_d;
      vld_q       <= vld_d;
      out_k_q     <= out_k_d;
      scan_k_q    <= scan_k_d;
      peak_mag_q  <= peak_mag_d;
      peak_lag_q  <= peak_lag_d;
      peak_freq_q <= peak_freq_d;
      if (res_we) begin
        for (int unsigned i = 0; i < NUM_FREQ; i++) begin
          res_q[i] <= res_tdata[i*MAG_BITS +: MAG_BITS];
        end
      end
    end
  end

  // Peak record packing.
  always_comb begin
    rec = '0;
    rec[REC_FREQ_LSB +: FREQ_W]  = peak_freq_q;
    rec[REC_LAG_LSB +: LAG_W]    = peak_lag_q;
    rec[REC_MAG_LSB +: MAG_BITS] = peak_mag_q;
  end

  assign s_axis_tready = s_rdy_q;
  assign corr_tdata    = vld_q ? mem_rdata : '0;
  assign corr_ref_idx  = out_k_q;
  assign corr_lag      = lag_q;
  assign corr_tvalid   = vld_q;
  assign corr_tlast    = vld_q && (out_k_q == REF_LAST);
  assign res_tready    = (state_q == WAIT_RES);
  assign m_axis_tvalid = (state_q == REPORT);
  assign m_axis_tdata  = rec;

`ifdef CAF_SWEEP_THRESHOLD_EN
  logic [MAG_BITS-1:0] thr_q;

  // Threshold is captured as the sweep starts and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      thr_q <= '0;
    end else if ((state_q == CAPTURE) && (state_d == STREAM)) begin
      thr_q <= threshold;
    end
  end

  assign m_axis_tuser = (state_q == REPORT) && (peak_mag_q >= thr_q);
`endif

endmodule

// File: tb/tb_caf_sweep_ctrl.sv
// Self-checking bench for caf_sweep_ctrl (CAP_LEN=8, REF_LEN=4, NUM_FREQ=2, MAG_BITS=16).
`timescale 1ns/1ps
module tb_caf_sweep_ctrl;

  localparam int unsigned CAP_LEN     = 8;
  localparam int unsigned REF_LEN     = 4;
  localparam int unsigned SAMPLE_BITS = 32;
  localparam int unsigned NUM_FREQ    = 2;
  localparam int unsigned MAG_BITS    = 16;
  localparam int unsigned NUM_LAGS    = 5;
  localparam int unsigned REC_W       = 20;
  localparam int unsigned BUDGET      = 3000;
  localparam int unsigned NV          = 6;

  typedef struct packed {
    logic [31:0]      base;   // sample i of the capture is base + i
    logic [4:0][15:0] b1;     // bin1 magnitude per lag, {lag4 .. lag0}
    logic [4:0][15:0] b0;     // bin0 magnitude per lag, {lag4 .. lag0}
    logic [15:0]      mag;    // expected peak record
    logic [2:0]       lag;
    logic             freq;
    logic [15:0]      thr;
    logic             user;
    logic             stall;  // random corr_tready/res_tvalid, record held 20 cycles
    logic             hold;   // keep s_axis_tvalid high after the capture
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  idx;
    logic [2:0]  lag;
    logic        last;
  } beat_t;

  logic                         clk = 1'b0;
  logic                         rst_n = 1'b1;
  logic [SAMPLE_BITS-1:0]       s_axis_tdata = '0;
  logic                         s_axis_tvalid = 1'b0;
  logic                         s_axis_tready;
  logic [SAMPLE_BITS-1:0]       corr_tdata;
  logic [1:0]                   corr_ref_idx;
  logic [2:0]                   corr_lag;
  logic                         corr_tvalid;
  logic                         corr_tlast;
  logic                         corr_tready = 1'b0;
  logic [NUM_FREQ*MAG_BITS-1:0] res_tdata = '0;
  logic                         res_tvalid = 1'b0;
  logic                         res_tready;
  logic [REC_W-1:0]             m_axis_tdata;
  logic                         m_axis_tvalid;
  logic                         m_axis_tready = 1'b0;
`ifdef CAF_SWEEP_THRESHOLD_EN
  logic [MAG_BITS-1:0]          threshold = '0;
  logic                         m_axis_tuser;
`endif

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  beat_t       corr_q[$];
  logic [20:0] rec_q[$];
  vec_t        vecs[NV];

  always #5 clk = ~clk;

  caf_sweep_ctrl #(
    .CAP_LEN     (CAP_LEN),
    .REF_LEN     (REF_LEN),
    .SAMPLE_BITS (SAMPLE_BITS),
    .NUM_FREQ    (NUM_FREQ),
    .MAG_BITS    (MAG_BITS)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .corr_tdata    (corr_tdata),
    .corr_ref_idx  (corr_ref_idx),
    .corr_lag      (corr_lag),
    .corr_tvalid   (corr_tvalid),
    .corr_tlast    (corr_tlast),
    .corr_tready   (corr_tready),
    .res_tdata     (res_tdata),
    .res_tvalid    (res_tvalid),
    .res_tready    (res_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
`ifdef CAF_SWEEP_THRESHOLD_EN
    ,
    .threshold     (threshold),
    .m_axis_tuser  (m_axis_tuser)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    s_axis_tvalid = 1'b0;
    corr_tready   = 1'b0;
    res_tvalid    = 1'b0;
    m_axis_tready = 1'b0;
  endtask

  task automatic check_all_quiet(input string name);
    check({name, "_valids"}, {59'd0, s_axis_tready, corr_tvalid, corr_tlast, res_tready, m_axis_tvalid}, 64'd0);
    check({name, "_data"}, {7'd0, corr_tdata, corr_ref_idx, corr_lag, m_axis_tdata}, 64'd0);
  endtask

  task automatic run_sweep(input vec_t v, input bit abort);
    logic [31:0] cap [CAP_LEN];
    beat_t       got_b, exp_b, prev_b;
    logic [20:0] exp_r;
    logic [19:0] exp_rec;
    int unsigned accepted, res_cnt, rec_hold, cycles;
    bit          cap_done, done, stalled, prev_hs_nonlast;

    accepted = 0; res_cnt = 0; rec_hold = 0; cycles = 0;
    cap_done = 1'b0; done = 1'b0; stalled = 1'b0; prev_hs_nonlast = 1'b0;
    prev_b   = '0;
    exp_rec  = {v.mag, v.lag, v.freq};
    rec_q.push_back({exp_rec, v.user});
`ifdef CAF_SWEEP_THRESHOLD_EN
    threshold = v.thr;
`endif

    while (!done) begin
      @(negedge clk);
      cycles++;
      if (cycles > BUDGET) begin
        n_cmp++;
        n_err++;
        $display("FAIL sweep_timeout: got %0d cycles, want <= %0d", cycles, BUDGET);
        break;
      end
      got_b = {corr_tdata, corr_ref_idx, corr_lag, corr_tlast};

      if (abort && corr_tvalid && (corr_lag == 3'd3)) begin
        rst_n = 1'b0;
        #1;
        check_all_quiet("midreset");
        drive_idle();
        corr_q.delete();
        rec_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end

`ifdef CAF_SWEEP_THRESHOLD_EN
      // Changing the threshold after the sweep starts must have no effect.
      if (cap_done) threshold = ~v.thr;
`endif

      // Correlator side: stability under stall, throughput, scoreboard.
      if (stalled) check("corr_hold", {25'd0, corr_tvalid, got_b}, {25'd0, 1'b1, prev_b});
      if (!v.stall && prev_hs_nonlast) check("corr_b2b", {63'd0, corr_tvalid}, 64'd1);
      corr_tready     = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled         = corr_tvalid && !corr_tready;
      prev_hs_nonlast = corr_tvalid && corr_tready && !corr_tlast;
      prev_b          = got_b;
      if (corr_tvalid && corr_tready) begin
        if (corr_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL corr_extra_beat: got beat 0x%0h, want none", got_b);
        end else begin
          exp_b = corr_q.pop_front();
          check("corr_beat", {26'd0, got_b}, {26'd0, exp_b});
        end
      end

      // Result side.
      res_tvalid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      res_tdata  = (res_cnt < NUM_LAGS) ? {v.b1[res_cnt], v.b0[res_cnt]} : '0;
      if (res_tready && res_tvalid) res_cnt++;

      // Peak record side.
      m_axis_tready = 1'b0;
      if (m_axis_tvalid) begin
        if (v.stall && (rec_hold < 20)) begin
          rec_hold++;
          check("rec_stall", {44'd0, m_axis_tdata}, {44'd0, exp_rec});
        end else begin
          m_axis_tready = 1'b1;
          if (rec_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rec_extra: got 0x%0h, want none", m_axis_tdata);
          end else begin
            exp_r = rec_q.pop_front();
            check("rec", {44'd0, m_axis_tdata}, {44'd0, exp_r[20:1]});
`ifdef CAF_SWEEP_THRESHOLD_EN
            check("rec_tuser", {63'd0, m_axis_tuser}, {63'd0, exp_r[0]});
`endif
          end
          done = 1'b1;
        end
      end

      // Sample source side.
      if (cap_done) check("s_ready_low", {63'd0, s_axis_tready}, 64'd0);
      if (accepted < CAP_LEN) s_axis_tvalid = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      else                    s_axis_tvalid = v.hold;
      s_axis_tdata = v.base + 32'(accepted);
      if (s_axis_tvalid && s_axis_tready) begin
        if (accepted < CAP_LEN) cap[accepted] = s_axis_tdata;
        accepted++;
        if (accepted == CAP_LEN) begin
          cap_done = 1'b1;
          for (int unsigned lag = 0; lag < NUM_LAGS; lag++) begin
            for (int unsigned k = 0; k < REF_LEN; k++) begin
              exp_b.data = cap[lag + k];
              exp_b.idx  = 2'(k);
              exp_b.lag  = 3'(lag);
              exp_b.last = (k == REF_LEN - 1);
              corr_q.push_back(exp_b);
            end
          end
        end
      end
    end

    @(negedge clk);
    drive_idle();
    check("s_ready_after_rec", {63'd0, s_axis_tready}, 64'd1);
    check("m_valid_after_rec", {63'd0, m_axis_tvalid}, 64'd0);
    check("samples_accepted", 64'(accepted), 64'(CAP_LEN));
    check("results_taken", 64'(res_cnt), 64'(NUM_LAGS));
    check("lags_streamed", 64'(corr_q.size()), 64'd0);
    corr_q.delete();
    rec_q.delete();
    if (!done) begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
    end
  endtask

  initial begin
    vecs[0] = '{base: 32'h10,
                b1: {16'd0, 16'd12, 16'd2, 16'd9, 16'd5},
                b0: {16'd0, 16'd1, 16'd12, 16'd9, 16'd3},
                mag: 16'd12, lag: 3'd2, freq: 1'b0, thr: 16'd12, user: 1'b1,
                stall: 1'b1, hold: 1'b1};
    vecs[1] = '{base: 32'h10,
                b1: {16'd0, 16'd12, 16'd2, 16'd9, 16'd5},
                b0: {16'd0, 16'd1, 16'd12, 16'd9, 16'd3},
                mag: 16'd12, lag: 3'd2, freq: 1'b0, thr: 16'd13, user: 1'b0,
                stall: 1'b0, hold: 1'b0};
    vecs[2] = '{base: 32'h40, b1: '0, b0: '0,
                mag: 16'd0, lag: 3'd0, freq: 1'b0, thr: 16'd0, user: 1'b1,
                stall: 1'b0, hold: 1'b1};
    vecs[3] = '{base: 32'h80,
                b1: {16'hFFFF, 16'd1, 16'd1, 16'd1, 16'd1},
                b0: '0,
                mag: 16'hFFFF, lag: 3'd4, freq: 1'b1, thr: 16'd0, user: 1'b1,
                stall: 1'b1, hold: 1'b0};
    vecs[4] = '{base: 32'hC0,
                b1: {16'd7, 16'd7, 16'd7, 16'd7, 16'd7},
                b0: {16'd7, 16'd7, 16'd7, 16'd7, 16'd7},
                mag: 16'd7, lag: 3'd0, freq: 1'b0, thr: 16'd0, user: 1'b1,
                stall: 1'b0, hold: 1'b1};
    vecs[5] = '{base: 32'h20,
                b1: {16'd2, 16'd8, 16'd5, 16'd3, 16'd1},
                b0: {16'd2, 16'd7, 16'd6, 16'd4, 16'd2},
                mag: 16'd8, lag: 3'd3, freq: 1'b1, thr: 16'd0, user: 1'b1,
                stall: 1'b1, hold: 1'b1};

    drive_idle();
    #1 rst_n = 1'b0;
    #1 check_all_quiet("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < NV; i++) begin
      run_sweep(vecs[i], 1'b0);
    end

    // Abort during lag 3, then a zero-result sweep must not see the old peak.
    run_sweep(vecs[1], 1'b1);
    run_sweep(vecs[2], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
